// File: rtl/mux_xor_toggle_pipe_if.sv
// Operand/result bus for mux_xor_toggle_pipe: one valid/ready channel in, one out.
// A word moves on a channel when valid & ready are both high at a rising edge;
// valid is held with stable data until that happens, and ready may not depend on valid.
interface mux_xor_toggle_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_a, in_b, in_c, in_s, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_s, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mux_xor_toggle_pipe.sv
// Two-stage valid/ready pipeline computing (s ? b : a) & (b ^ c) per lane, with a
// saturating counter of output bit toggles between consecutive delivered words.
module mux_xor_toggle_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_xor_toggle_pipe_if.slave bus,
  input  logic                 tog_clr,
  output logic [CNT_W-1:0]     tog_cnt
);
  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] last_out_q, last_out_d;
  logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;

  logic             s2_take;
  logic             accept;
  logic             xfer;
  logic             deliver;
  logic [WIDTH-1:0] lane_r;
  logic [WIDTH-1:0] diff;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_sat;

  always_comb begin
    s2_take = ~out_valid_q | bus.out_ready;
    accept  = bus.in_valid & (~s1_valid_q | s2_take);
    xfer    = s1_valid_q & s2_take;
    deliver = out_valid_q & bus.out_ready;
    lane_r  = ((bus.in_s & bus.in_b) | (~bus.in_s & bus.in_a)) & (bus.in_b ^ bus.in_c);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = lane_r;
    end else if (xfer) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 data only moves on a transfer, so it stays frozen while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = s1_data_q;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    diff = out_data_q ^ last_out_q;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(diff[i]);
    end
    sum = SUM_W'(tog_cnt_q) + SUM_W'(pop);
    if (sum > SUM_W'({CNT_W{1'b1}})) cnt_sat = '1;
    else                             cnt_sat = sum[CNT_W-1:0];
  end

  // Clear wins over a same-cycle handshake, but last_out still tracks the word.
  always_comb begin
    tog_cnt_d  = tog_cnt_q;
    last_out_d = last_out_q;
    if (deliver) last_out_d = out_data_q;
    if (tog_clr)      tog_cnt_d = '0;
    else if (deliver) tog_cnt_d = cnt_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_out_q  <= '0;
      tog_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_out_q  <= last_out_d;
      tog_cnt_q   <= tog_cnt_d;
    end
  end

  assign bus.in_ready  = ~s1_valid_q | s2_take;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign tog_cnt       = tog_cnt_q;
endmodule
